// File: rtl/ddr_region_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ddr_region_arbiter
// Description : Shares one Avalon-style DDR master port between three fixed
//               clients (0 save-state, 1 object framebuffer, 2 object data).
//               Each client supplies a region-relative offset; the arbiter
//               adds the client's DDR base, runs one burst at a time and
//               routes write-beat / read-beat handshakes to the granted
//               client. Save-state has absolute priority; FB and OD share
//               round-robin.
// Options     : `define DDR_ARB_TIMEOUT_EN enables a stall watchdog that
//               aborts a burst (ack + err) after TIMEOUT idle cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_region_arbiter #(
    parameter logic [31:0] SS_BASE = 32'h0000_0000,
    parameter logic [31:0] FB_BASE = 32'h0010_0000,
    parameter logic [31:0] OD_BASE = 32'h0020_0000,
    parameter int          OFS_W   = 20,
    parameter int          TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         req,
    input  logic [2:0]         we,
    input  logic [3*OFS_W-1:0] ofs,
    input  logic [3*8-1:0]     burst,
    input  logic [3*64-1:0]    wdata,
    input  logic [3*8-1:0]     be,
    output logic [2:0]         ack,
    output logic [2:0]         wbeat,
    output logic [2:0]         rvalid,
    output logic [63:0]        rdata,
    output logic               err,
    output logic [31:0]        ddr_addr,
    output logic [7:0]         ddr_burstcnt,
    output logic               ddr_read,
    output logic               ddr_write,
    output logic [63:0]        ddr_wdata,
    output logic [7:0]         ddr_byteenable,
    input  logic               ddr_busy,
    input  logic [63:0]        ddr_rdata,
    input  logic               ddr_rdata_ready
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CMD   = 2'd1;
    localparam logic [1:0] c_ST_RDATA = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;

    // Grant candidate and its request fields
    logic [1:0]       w_sel;
    logic [OFS_W-1:0] w_ofs_sel;
    logic [OFS_W-1:0] w_ofs_al;
    logic [7:0]       w_burst_sel;
    logic             w_we_sel;
    logic [31:0]      w_base_sel;
    logic [31:0]      w_addr_sel;

    // Latched burst context
    logic [1:0]       r_gidx;
    logic [2:0]       r_gnt;
    logic             r_we;
    logic [7:0]       r_burst;
    logic [7:0]       r_cnt;
    logic [31:0]      r_addr;
    logic             r_rr_od;      // 1: OD wins the next FB/OD tie

    // Granted client's live write beat
    logic [63:0]      w_wdata_gnt;
    logic [7:0]       w_be_gnt;

    // Handshake qualifiers
    logic             w_cmd_acc;
    logic             w_wr_last;
    logic             w_rd_beat;
    logic             w_rd_done;
    logic             w_timeout;

    // Registered read return path
    logic [2:0]       r_rvalid;
    logic [63:0]      r_rdata;

    // Offset low bits are discarded by the 8-byte alignment
    logic             w_unused_ofs;
    assign w_unused_ofs = ^w_ofs_sel[2:0];

    // Priority select: SS absolute, then FB/OD by round-robin pointer
    always_comb begin
        w_sel = 2'd0;
        if (req[0]) begin
            w_sel = 2'd0;
        end else if (req[1] && req[2]) begin
            w_sel = r_rr_od ? 2'd2 : 2'd1;
        end else if (req[1]) begin
            w_sel = 2'd1;
        end else if (req[2]) begin
            w_sel = 2'd2;
        end
    end

    // Mux the candidate client's request fields and compute its DDR address
    always_comb begin
        w_ofs_sel   = ofs[0 +: OFS_W];
        w_burst_sel = burst[7:0];
        w_we_sel    = we[0];
        w_base_sel  = SS_BASE;
        case (w_sel)
            2'd1: begin
                w_ofs_sel   = ofs[OFS_W +: OFS_W];
                w_burst_sel = burst[15:8];
                w_we_sel    = we[1];
                w_base_sel  = FB_BASE;
            end
            2'd2: begin
                w_ofs_sel   = ofs[2*OFS_W +: OFS_W];
                w_burst_sel = burst[23:16];
                w_we_sel    = we[2];
                w_base_sel  = OD_BASE;
            end
            default: begin
                w_ofs_sel   = ofs[0 +: OFS_W];
                w_burst_sel = burst[7:0];
                w_we_sel    = we[0];
                w_base_sel  = SS_BASE;
            end
        endcase
        w_ofs_al   = {w_ofs_sel[OFS_W-1:3], 3'b000};
        w_addr_sel = w_base_sel + 32'(w_ofs_al);
    end

    // Mux the granted client's current write beat
    always_comb begin
        w_wdata_gnt = wdata[63:0];
        w_be_gnt    = be[7:0];
        case (r_gidx)
            2'd1: begin
                w_wdata_gnt = wdata[127:64];
                w_be_gnt    = be[15:8];
            end
            2'd2: begin
                w_wdata_gnt = wdata[191:128];
                w_be_gnt    = be[23:16];
            end
            default: begin
                w_wdata_gnt = wdata[63:0];
                w_be_gnt    = be[7:0];
            end
        endcase
    end

    assign w_cmd_acc = (r_state == c_ST_CMD) && !ddr_busy;
    assign w_wr_last = w_cmd_acc && r_we && (r_cnt == r_burst - 8'd1);
    assign w_rd_beat = (r_state == c_ST_RDATA) && ddr_rdata_ready && (r_cnt != r_burst);
    assign w_rd_done = (r_state == c_ST_RDATA) && (r_cnt == r_burst);

`ifdef DDR_ARB_TIMEOUT_EN
    localparam logic [15:0] c_STALL_LIM = 16'(TIMEOUT - 1);

    logic [15:0] r_stall;
    logic        r_abort;
    logic        w_active;
    logic        w_progress;

    assign w_active   = (r_state == c_ST_CMD) || (r_state == c_ST_RDATA);
    assign w_progress = w_cmd_acc || w_rd_beat;
    assign w_timeout  = w_active && !w_progress && !w_rd_done && (r_stall == c_STALL_LIM);

    // Stall watchdog: cleared on any accepted command/beat, counts while waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall <= 16'd0;
            r_abort <= 1'b0;
        end else begin
            r_stall <= (!w_active || w_progress) ? 16'd0 : r_stall + 16'd1;
            r_abort <= w_timeout;
        end
    end

    assign err = (r_state == c_ST_DONE) && r_abort;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; zero-length bursts skip straight to DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (|req) begin
                    w_next = (w_burst_sel == 8'd0) ? c_ST_DONE : c_ST_CMD;
                end
            end
            c_ST_CMD: begin
                if (w_timeout) begin
                    w_next = c_ST_DONE;
                end else if (w_cmd_acc) begin
                    if (!r_we) begin
                        w_next = c_ST_RDATA;
                    end else if (w_wr_last) begin
                        w_next = c_ST_DONE;
                    end
                end
            end
            c_ST_RDATA: begin
                if (w_rd_done || w_timeout) begin
                    w_next = c_ST_DONE;
                end
            end
            default: begin
                w_next = c_ST_IDLE;
            end
        endcase
    end

    // Grant capture, round-robin pointer and beat counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gidx  <= 2'd0;
            r_gnt   <= 3'b000;
            r_we    <= 1'b0;
            r_burst <= 8'd0;
            r_cnt   <= 8'd0;
            r_addr  <= 32'd0;
            r_rr_od <= 1'b0;
        end else begin
            if ((r_state == c_ST_IDLE) && (|req)) begin
                r_gidx  <= w_sel;
                r_gnt   <= 3'b001 << w_sel;
                r_we    <= w_we_sel;
                r_burst <= w_burst_sel;
                r_addr  <= w_addr_sel;
                r_cnt   <= 8'd0;
                if (w_sel == 2'd1) begin
                    r_rr_od <= 1'b1;
                end else if (w_sel == 2'd2) begin
                    r_rr_od <= 1'b0;
                end
            end else if (w_cmd_acc && r_we) begin
                r_cnt <= r_cnt + 8'd1;
            end else if (w_cmd_acc) begin
                r_cnt <= 8'd0;
            end else if (w_rd_beat) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Read return: one-cycle registered forward of each accepted DDR beat
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid <= 3'b000;
            r_rdata  <= 64'd0;
        end else begin
            r_rvalid <= w_rd_beat ? r_gnt : 3'b000;
            if (w_rd_beat) begin
                r_rdata <= ddr_rdata;
            end
        end
    end

    // Output decode: DDR command only in CMD, ack only in DONE
    always_comb begin
        ack            = 3'b000;
        wbeat          = 3'b000;
        ddr_addr       = 32'd0;
        ddr_burstcnt   = 8'd0;
        ddr_read       = 1'b0;
        ddr_write      = 1'b0;
        ddr_wdata      = 64'd0;
        ddr_byteenable = 8'd0;
        case (r_state)
            c_ST_CMD: begin
                ddr_addr     = r_addr;
                ddr_burstcnt = r_burst;
                if (r_we) begin
                    ddr_write      = 1'b1;
                    ddr_wdata      = w_wdata_gnt;
                    ddr_byteenable = w_be_gnt;
                    if (!ddr_busy) begin
                        wbeat = r_gnt;
                    end
                end else begin
                    ddr_read = 1'b1;
                end
            end
            c_ST_DONE: begin
                ack = r_gnt;
            end
            default: begin
                ack = 3'b000;
            end
        endcase
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;

endmodule
`default_nettype wire
